fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the 512-entry sync FIFO between NUM_REQ producers
//  (e.g. weight/activation loaders feeding the systolic array).
//  Round-robin burst arbitration with per-requester valid/ready handshake.
//  Guarantees fifo_wr_en is never asserted while fifo_full=1; the FIFO write port has
//  no overwrite protection of its own.
// PARAMETERS
//  NUM_REQ    4           number of requesters (2..8)
//  DATA_W     `WORD_SIZE  write data width
//  BURST_LEN  16          max beats per grant before forced re-arbitration (1..256)
//  ID_W       $clog2(NUM_REQ)  localparam, owner id width
// PORTS
//  clk           in   1               clock
//  rst           in   1               asynchronous reset, active-high
//  req_valid     in   NUM_REQ         requester i has a beat on req_data[i]
//  req_data      in   NUM_REQ*DATA_W  flattened data, slice i = [i*DATA_W +: DATA_W]
//  req_ready     out  NUM_REQ         beat of requester i accepted this cycle if valid&ready
//  fifo_full     in   1               FIFO full flag
//  fifo_wr_en    out  1               FIFO write strobe
//  fifo_wr_data  out  DATA_W          FIFO write data
//  grant_vld     out  1               a requester currently owns the port
//  grant_id      out  ID_W            current owner (valid when grant_vld)
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, rr_ptr=NUM_REQ-1 (req 0 highest first priority),
//    beat_cnt=0; hence req_ready=0, fifo_wr_en=0, grant_vld=0, grant_id=0.
//  - FSM IDLE: if any req_valid, pick first valid index after rr_ptr (wrapping);
//    register owner, rr_ptr<=owner, beat_cnt<=0, go GRANT. Arbitration = 1 cycle.
//  - FSM GRANT: req_ready[owner] = !fifo_full; all other ready = 0 (combinational).
//    fifo_wr_en = req_valid[owner] & !fifo_full; fifo_wr_data = req_data[owner].
//    Each accepted beat increments beat_cnt.
//  - Release (GRANT->IDLE next cycle) on: accepted beat with beat_cnt==BURST_LEN-1,
//    or req_valid[owner]==0 in GRANT. One idle bubble between grants, always.
//  - fifo_full in GRANT: stall, grant held, beat_cnt unchanged; no release on full.
//  - Requester may not drop valid mid-burst without losing grant; data need not hold
//    once ready is low (no beat taken).
//  - Reset mid-burst: immediate return to reset values; partial burst is abandoned.
//  - beat_cnt width $clog2(BURST_LEN+1); no wrap possible due to release rule.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: adds inputs stat_clr (1) and output stat_beats
//    (NUM_REQ*16): per-requester accepted-beat counters, saturating at 16'hFFFF,
//    synchronously zeroed by stat_clr (clear wins over a same-cycle increment),
//    reset to 0.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  Shared package fifo_arb_pkg: FSM state encoding (IDLE=1'b0, GRANT=1'b1),
//    stats counter width constant (16).
//  Sub-module rr_arbiter: combinational round-robin pick (req vector, rr_ptr ->
//    onehot/id, any); instantiated once. FSM, beat counter, muxes in top.
// TESTING
//  1 Reset, all valid=0 -> fifo_wr_en=0, req_ready=0, grant_vld=0 for 10 cycles.
//  2 Only req 2 valid, 20 beats, fifo never full -> 16 beats, 1 idle cycle,
//    re-grant to 2, 4 beats; FIFO contents in order.
//  3 All 4 valid continuously -> grant order 0,1,2,3,0, 16 beats each,
//    one bubble between grants.
//  4 fifo_full forced high 5 cycles mid-burst of req 1 -> no wr_en while full,
//    grant kept, burst resumes, total 16 beats.
//  5 Req 3 drops valid after 3 beats -> release, next valid requester granted
//    after 1 idle cycle.
//  6 FIFO_ARB_STATS_EN: after test 3, stat_beats = 32,16,16,16 for req 0..3;
//    stat_clr -> all 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Supplies a default WORD_SIZE when the surrounding project does not define one.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_onehot_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               any_o
);

    // Scan from farthest to nearest so the nearest request after ptr_i wins.
    always_comb begin
        gnt_onehot_o = '0;
        gnt_id_o     = '0;
        any_o        = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int unsigned idx;
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                gnt_onehot_o      = '0;
                gnt_onehot_o[idx] = 1'b1;
                gnt_id_o          = ID_W'(idx);
                any_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional FIFO_ARB_STATS_EN adds per-requester saturating accepted-beat counters.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = `WORD_SIZE,
    parameter  int BURST_LEN = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      grant_vld,
    output logic [ID_W-1:0]           grant_id
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*STAT_W-1:0] stat_beats
`endif
);

    localparam int              CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_e         state_q;
    logic [ID_W-1:0]    owner_q;
    logic [NUM_REQ-1:0] owner_oh_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;
    logic               in_grant;
    logic               owner_valid;
    logic               beat_acc;
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i        (req_valid),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (pick_onehot),
        .gnt_id_o     (pick_id),
        .any_o        (pick_any)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    assign in_grant     = (state_q == ST_GRANT);
    assign owner_valid  = |(req_valid & owner_oh_q);
    assign beat_acc     = in_grant & owner_valid & ~fifo_full;
    assign req_ready    = (in_grant && !fifo_full) ? owner_oh_q : '0;
    assign fifo_wr_en   = beat_acc;
    assign fifo_wr_data = data_arr[owner_q];
    assign grant_vld    = in_grant;
    assign grant_id     = owner_q;

    // A full FIFO freezes the burst: neither beat_cnt nor the grant changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            owner_oh_q <= NUM_REQ'(1);
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q    <= ST_GRANT;
                        owner_q    <= pick_id;
                        owner_oh_q <= pick_onehot;
                        rr_ptr_q   <= pick_id;
                        beat_cnt_q <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!owner_valid) begin
                        state_q <= ST_IDLE;
                    end else if (beat_acc) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q    <= ST_IDLE;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        logic [STAT_W-1:0] cnt_q;
        logic [STAT_W-1:0] cnt_d;

        // Clear takes priority over a same-cycle beat; counting stops at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (stat_clr) begin
                cnt_d = '0;
            end else if (req_valid[gi] && req_ready[gi] && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stat_beats[gi*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, round-robin order, full stalls, early release.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 16;
    localparam int ID_W      = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      grant_vld;
    logic [ID_W-1:0]           grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic                      stat_clr;
    logic [NUM_REQ*16-1:0]     stat_beats;
    logic                      stat_cmd = 1'b0;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_vld    (grant_vld),
        .grant_id     (grant_id)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_beats   (stat_beats)
`endif
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int   rem [NUM_REQ];
    int   seq [NUM_REQ];
    int   exp_seq [NUM_REQ];
    logic [NUM_REQ-1:0] acc;
    logic full_cmd;
    int   cyc;
    int   data_err;
    int   proto_err;
    int   seg_id[$];
    int   seg_beats[$];
    int   seg_start[$];
    int   seg_end[$];
    logic prev_gv;
    logic [ID_W-1:0] prev_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]               = (rem[i] != 0);
            req_data[i*DATA_W +: DATA_W] = {8'(i), 24'(seq[i])};
        end
        fifo_full = full_cmd;
`ifdef FIFO_ARB_STATS_EN
        stat_clr = stat_cmd;
`endif
    endtask

    // Called at negedge: records beats, protocol violations and grant segments.
    task automatic sample();
        acc = req_valid & req_ready;
        if (fifo_wr_en !== (|acc)) proto_err++;
        if ((req_ready & ~(4'b0001 << grant_id)) != 0) proto_err++;
        if (!grant_vld && (req_ready != 0)) proto_err++;
        if (fifo_wr_en && fifo_full) proto_err++;
        if (fifo_wr_en === 1'b1) begin
            if (fifo_wr_data !== {8'(grant_id), 24'(exp_seq[grant_id])}) data_err++;
            exp_seq[grant_id]++;
        end
        if (grant_vld === 1'b1) begin
            if (!prev_gv || (grant_id != prev_id)) begin
                seg_id.push_back(int'(grant_id));
                seg_beats.push_back(0);
                seg_start.push_back(cyc);
                seg_end.push_back(cyc);
            end
            seg_end[seg_end.size()-1] = cyc;
            if (fifo_wr_en) seg_beats[seg_beats.size()-1]++;
        end
        prev_gv = grant_vld;
        prev_id = grant_id;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic clear_trace();
        seg_id.delete();
        seg_beats.delete();
        seg_start.delete();
        seg_end.delete();
        prev_gv   = 1'b0;
        prev_id   = '0;
        data_err  = 0;
        proto_err = 0;
        cyc       = 0;
    endtask

    task automatic pad_segs(input int n);
        while (seg_id.size() < n) begin
            seg_id.push_back(-1);
            seg_beats.push_back(-1);
            seg_start.push_back(-100);
            seg_end.push_back(-100);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i]     = 0;
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        acc      = '0;
        full_cmd = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_trace();
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (grant_vld === 1'b0);
            for (int i = 0; i < NUM_REQ; i++) if (rem[i] != 0) done = 1'b0;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Checks burst k: owner, beat count and idle gap to the previous burst.
    task automatic check_seg(input int k, input int id, input int beats);
        check($sformatf("seg%0d_id", k), seg_id[k], id);
        check($sformatf("seg%0d_beats", k), seg_beats[k], beats);
        if (k > 0) check($sformatf("seg%0d_gap", k), seg_start[k] - seg_end[k-1] - 1, 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        full_cmd = 1'b0;
        drive();

        // Test 1: idle after reset
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            check("t1_wr_en", 32'(fifo_wr_en), 32'd0);
            check("t1_ready", 32'(req_ready), 32'd0);
            check("t1_grant_vld", 32'(grant_vld), 32'd0);
            check("t1_grant_id", 32'(grant_id), 32'd0);
        end

        // Test 2: single requester, 20 beats -> 16 + bubble + 4
        rem[2] = 20;
        run_until_idle("t2_done", 100);
        check("t2_nseg", seg_id.size(), 2);
        pad_segs(2);
        check_seg(0, 2, 16);
        check_seg(1, 2, 4);
        check("t2_total", exp_seq[2], 20);
        check("t2_data_err", data_err, 0);
        check("t2_proto_err", proto_err, 0);

        // Test 3: all requesters valid continuously
        do_reset();
        rem[0] = 32;
        rem[1] = 16;
        rem[2] = 16;
        rem[3] = 16;
        run_until_idle("t3_done", 200);
        check("t3_nseg", seg_id.size(), 5);
        pad_segs(5);
        check_seg(0, 0, 16);
        check_seg(1, 1, 16);
        check_seg(2, 2, 16);
        check_seg(3, 3, 16);
        check_seg(4, 0, 16);
        check("t3_total0", exp_seq[0], 32);
        check("t3_total3", exp_seq[3], 16);
        check("t3_data_err", data_err, 0);
        check("t3_proto_err", proto_err, 0);

`ifdef FIFO_ARB_STATS_EN
        // Test 6: beat statistics after test 3, then clear
        check("t6_stat0", 32'(stat_beats[0  +: 16]), 32'd32);
        check("t6_stat1", 32'(stat_beats[16 +: 16]), 32'd16);
        check("t6_stat2", 32'(stat_beats[32 +: 16]), 32'd16);
        check("t6_stat3", 32'(stat_beats[48 +: 16]), 32'd16);
        stat_cmd = 1'b1;
        step();
        stat_cmd = 1'b0;
        step();
        check("t6_stat_clr", 32'(stat_beats), 32'd0);
`endif

        // Test 4: fifo_full for 5 cycles in the middle of req 1's burst
        clear_trace();
        rem[1] = 16;
        repeat (3) step();
        full_cmd = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t4_wr_en_full", 32'(fifo_wr_en), 32'd0);
            check("t4_ready_full", 32'(req_ready), 32'd0);
            check("t4_grant_vld", 32'(grant_vld), 32'd1);
            check("t4_grant_id", 32'(grant_id), 32'd1);
        end
        full_cmd = 1'b0;
        run_until_idle("t4_done", 100);
        check("t4_nseg", seg_id.size(), 1);
        pad_segs(1);
        check_seg(0, 1, 16);
        check("t4_total1", exp_seq[1], 32);
        check("t4_data_err", data_err, 0);
        check("t4_proto_err", proto_err, 0);

        // Test 5: req 3 drops valid after 3 beats, req 0 follows after one idle cycle
        clear_trace();
        rem[3] = 3;
        rem[0] = 5;
        run_until_idle("t5_done", 100);
        check("t5_nseg", seg_id.size(), 2);
        pad_segs(2);
        check_seg(0, 3, 3);
        check_seg(1, 0, 5);
        check("t5_data_err", data_err, 0);
        check("t5_proto_err", proto_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
